// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a per-register busy
// scoreboard. Reads are registered with write-first bypass; when several write
// ports hit the same register in one cycle the highest-index port wins.
// Optional hardwired zero register at address 0.
module regfile_mp #(
    parameter int N        = 32,
    parameter int R        = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int A       = (R > 1) ? $clog2(R) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*A-1:0]     wr_addr,
    input  logic [NWR*N-1:0]     wr_data,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*A-1:0]     rd_addr,
    output logic [NRD*N-1:0]     rd_data,
    output logic [NRD-1:0]       rd_valid,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 rsv_en,
    input  logic [A-1:0]         rsv_addr,
    output logic [R-1:0]         busy
);

    logic [N-1:0]     regs_q [R];
    logic [N-1:0]     regs_d [R];
    logic [R-1:0]     busy_q;
    logic [R-1:0]     busy_d;
    logic [NRD*N-1:0] rd_data_q;
    logic [NRD*N-1:0] rd_data_d;
    logic [NRD-1:0]   rd_busy_q;
    logic [NRD-1:0]   rd_busy_d;
    logic [NRD-1:0]   rd_valid_q;
    logic [NRD-1:0]   rd_valid_d;

    // An address names real, writable storage: inside the array and not the
    // hardwired zero register. Everything else reads as 0 and is never busy.
    function automatic logic addr_ok(input logic [A-1:0] a);
        logic ok;
        ok = (int'(a) < R);
        if ((ZERO_REG != 0) && (a == '0)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Next register/scoreboard state: writes in ascending port order so the
    // highest-index port lands last, then the reservation so it outranks a
    // same-cycle write to the same register.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && addr_ok(wr_addr[j*A +: A])) begin
                regs_d[wr_addr[j*A +: A]] = wr_data[j*N +: N];
                busy_d[wr_addr[j*A +: A]] = 1'b0;
            end
        end
        if (rsv_en && addr_ok(rsv_addr)) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    // Read ports sample the post-update state, giving write-first bypass and
    // the busy bit as it stands after this cycle's writes and reservation.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_busy_d  = rd_busy_q;
        rd_valid_d = rd_en;
        for (int k = 0; k < NRD; k++) begin
            if (rd_en[k]) begin
                if (addr_ok(rd_addr[k*A +: A])) begin
                    rd_data_d[k*N +: N] = regs_d[rd_addr[k*A +: A]];
                    rd_busy_d[k]        = busy_d[rd_addr[k*A +: A]];
                end else begin
                    rd_data_d[k*N +: N] = '0;
                    rd_busy_d[k]        = 1'b0;
                end
            end
        end
    end

    // State registers with synchronous reset that also discards reservations.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < R; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            rd_data_q  <= '0;
            rd_busy_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            for (int i = 0; i < R; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_busy_q  <= rd_busy_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_busy  = rd_busy_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp. A behavioural model of the
// default configuration (32x32, 2 read, 2 write, zero register) is checked
// against the DUT every cycle; literal expectations pin the model, and a
// second instance covers the 64-bit / 16-entry / 3-read / 1-write variant.
module tb_regfile_mp;

    logic        clk;
    logic        rst;

    // Default-parameter instance
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_valid;
    logic [1:0]  rd_busy;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [31:0] busy;

    // Swept-parameter instance
    logic [0:0]   sw_wr_en;
    logic [3:0]   sw_wr_addr;
    logic [63:0]  sw_wr_data;
    logic [2:0]   sw_rd_en;
    logic [11:0]  sw_rd_addr;
    logic [191:0] sw_rd_data;
    logic [2:0]   sw_rd_valid;
    logic [2:0]   sw_rd_busy;
    logic         sw_rsv_en;
    logic [3:0]   sw_rsv_addr;
    logic [15:0]  sw_busy;

    int checks;
    int errors;

    // Model state
    logic [31:0] m_mem [32];
    logic [31:0] m_busy;
    logic [63:0] exp_rd_data;
    logic [1:0]  exp_rd_valid;
    logic [1:0]  exp_rd_busy;
    bit          model_started;

    regfile_mp dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_busy  (rd_busy),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy     (busy)
    );

    regfile_mp #(.N(64), .R(16), .NRD(3), .NWR(1), .ZERO_REG(0)) dut_sweep (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (sw_wr_en),
        .wr_addr  (sw_wr_addr),
        .wr_data  (sw_wr_data),
        .rd_en    (sw_rd_en),
        .rd_addr  (sw_rd_addr),
        .rd_data  (sw_rd_data),
        .rd_valid (sw_rd_valid),
        .rd_busy  (sw_rd_busy),
        .rsv_en   (sw_rsv_en),
        .rsv_addr (sw_rsv_addr),
        .busy     (sw_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Distinct load pattern for the reset test
    function automatic logic [31:0] load_val(input int i);
        return 32'(32'h1000_0000 + i * 257);
    endfunction

    // Data of the highest-index enabled write port targeting address a
    function automatic bit write_hit(input int a, output logic [31:0] v);
        v = '0;
        for (int j = 1; j >= 0; j--) begin
            if (wr_en[j] && int'(wr_addr[j*5 +: 5]) == a) begin
                v = wr_data[j*32 +: 32];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] we, input logic [4:0] wa0,
                                 input logic [31:0] wd0, input logic [4:0] wa1,
                                 input logic [31:0] wd1, input logic [1:0] re,
                                 input logic [4:0] ra0, input logic [4:0] ra1,
                                 input logic rs, input logic [4:0] rsa);
        wr_en    = we;
        wr_addr  = {wa1, wa0};
        wr_data  = {wd1, wd0};
        rd_en    = re;
        rd_addr  = {ra1, ra0};
        rsv_en   = rs;
        rsv_addr = rsa;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleStep();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
    endtask

    // Behavioural model: the register file as an array plus a busy vector,
    // updated at every rising edge from the inputs presented to that edge.
    initial begin : model
        int          a;
        logic [31:0] v;
        logic        nb;
        model_started = 1'b0;
        forever begin
            @(posedge clk);
            model_started = 1'b1;
            if (rst) begin
                for (int i = 0; i < 32; i++) m_mem[i] = '0;
                m_busy       = '0;
                exp_rd_data  = '0;
                exp_rd_valid = '0;
                exp_rd_busy  = '0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (rd_en[k]) begin
                        a = int'(rd_addr[k*5 +: 5]);
                        if (a == 0) begin
                            exp_rd_data[k*32 +: 32] = '0;
                            exp_rd_busy[k]          = 1'b0;
                        end else begin
                            nb = m_busy[a];
                            if (write_hit(a, v)) begin
                                nb = 1'b0;
                            end else begin
                                v = m_mem[a];
                            end
                            if (rsv_en && int'(rsv_addr) == a) nb = 1'b1;
                            exp_rd_data[k*32 +: 32] = v;
                            exp_rd_busy[k]          = nb;
                        end
                    end
                end
                exp_rd_valid = rd_en;
                for (int i = 1; i < 32; i++) begin
                    if (write_hit(i, v)) begin
                        m_mem[i]  = v;
                        m_busy[i] = 1'b0;
                    end
                    if (rsv_en && int'(rsv_addr) == i) m_busy[i] = 1'b1;
                end
            end
        end
    end

    // Every cycle, compare all outputs of the default instance with the model.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (model_started) begin
                for (int k = 0; k < 2; k++) begin
                    checkOutput($sformatf("model rd_data[%0d]", k),
                                64'(rd_data[k*32 +: 32]), 64'(exp_rd_data[k*32 +: 32]));
                    checkOutput($sformatf("model rd_busy[%0d]", k),
                                64'(rd_busy[k]), 64'(exp_rd_busy[k]));
                    checkOutput($sformatf("model rd_valid[%0d]", k),
                                64'(rd_valid[k]), 64'(exp_rd_valid[k]));
                end
                checkOutput("model busy", 64'(busy), 64'(m_busy));
            end
        end
    end

    // Directed stimulus with hand-computed expectations
    initial begin : stimulus
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        wr_en       = '0;
        wr_addr     = '0;
        wr_data     = '0;
        rd_en       = '0;
        rd_addr     = '0;
        rsv_en      = 1'b0;
        rsv_addr    = '0;
        sw_wr_en    = '0;
        sw_wr_addr  = '0;
        sw_wr_data  = '0;
        sw_rd_en    = '0;
        sw_rd_addr  = '0;
        sw_rsv_en   = 1'b0;
        sw_rsv_addr = '0;
        @(negedge clk);
        idleStep();
        checkOutput("reset busy", 64'(busy), 64'h0);
        checkOutput("reset rd_valid", 64'(rd_valid), 64'h0);
        rst = 1'b0;

        $display("[TB] loading registers 1..31");
        for (int i = 1; i < 32; i++) begin
            applyStimulus(2'b01, 5'(i), load_val(i), 5'd0, 32'h0, 2'b00, 5'd0, 5'd0,
                          (i == 31), 5'd10);
        end
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd31, 1'b0, 5'd0);
        checkOutput("preload r5", 64'(rd_data[31:0]), 64'h1000_0505);
        checkOutput("preload r31", 64'(rd_data[63:32]), 64'h1000_1F1F);
        checkOutput("preload busy r10", 64'(busy), 64'h0000_0400);

        // Reset with a write and a read presented; both must be ignored
        rst = 1'b1;
        applyStimulus(2'b01, 5'd5, 32'hAAAA_AAAA, 5'd0, 32'h0, 2'b11, 5'd5, 5'd31, 1'b1, 5'd3);
        rst = 1'b0;
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd31, 1'b0, 5'd0);
        checkOutput("post-reset r5", 64'(rd_data[31:0]), 64'h0);
        checkOutput("post-reset r31", 64'(rd_data[63:32]), 64'h0);
        checkOutput("post-reset rd_busy", 64'(rd_busy), 64'h0);
        checkOutput("post-reset busy", 64'(busy), 64'h0);

        // Write-first bypass
        applyStimulus(2'b01, 5'd7, 32'hDEAD_BEEF, 5'd0, 32'h0, 2'b10, 5'd0, 5'd7, 1'b0, 5'd0);
        checkOutput("bypass rd_data[1]", 64'(rd_data[63:32]), 64'hDEAD_BEEF);
        checkOutput("bypass rd_valid", 64'(rd_valid), 64'h2);

        // Write conflict, seen both through the bypass and from storage
        applyStimulus(2'b11, 5'd9, 32'h11, 5'd9, 32'h22, 2'b10, 5'd0, 5'd9, 1'b0, 5'd0);
        checkOutput("conflict bypass r9", 64'(rd_data[63:32]), 64'h22);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd9, 5'd0, 1'b0, 5'd0);
        checkOutput("conflict r9", 64'(rd_data[31:0]), 64'h22);

        // Zero register
        applyStimulus(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0, 2'b10, 5'd0, 5'd0, 1'b1, 5'd0);
        checkOutput("zero bypass r0", 64'(rd_data[63:32]), 64'h0);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, 1'b0, 5'd0);
        checkOutput("zero r0 data", 64'(rd_data), 64'h0);
        checkOutput("zero r0 rd_busy", 64'(rd_busy), 64'h0);
        checkOutput("zero busy[0]", 64'(busy[0]), 64'h0);

        // Scoreboard
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd4);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd4, 5'd0, 1'b0, 5'd0);
        checkOutput("reserved r4 rd_busy", 64'(rd_busy[0]), 64'h1);
        checkOutput("reserved busy", 64'(busy), 64'h0000_0010);
        applyStimulus(2'b10, 5'd0, 32'h0, 5'd4, 32'h55, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd4, 5'd0, 1'b0, 5'd0);
        checkOutput("written r4 data", 64'(rd_data[31:0]), 64'h55);
        checkOutput("written r4 rd_busy", 64'(rd_busy[0]), 64'h0);
        applyStimulus(2'b01, 5'd4, 32'h77, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd4);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd4, 5'd0, 1'b0, 5'd0);
        checkOutput("rsv+write r4 data", 64'(rd_data[31:0]), 64'h77);
        checkOutput("rsv+write r4 rd_busy", 64'(rd_busy[0]), 64'h1);
        checkOutput("rsv+write busy", 64'(busy), 64'h0000_0010);

        // Disabled read port holds its data
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd7, 5'd9, 1'b0, 5'd0);
        checkOutput("hold rd_data[0]", 64'(rd_data[31:0]), 64'h77);
        checkOutput("hold rd_valid", 64'(rd_valid), 64'h0);

        // Reset mid-operation discards reservations
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd12);
        rst = 1'b1;
        idleStep();
        rst = 1'b0;
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd12, 5'd4, 1'b0, 5'd0);
        checkOutput("mid-reset r12 rd_busy", 64'(rd_busy), 64'h0);
        checkOutput("mid-reset r4 data", 64'(rd_data[63:32]), 64'h0);
        checkOutput("mid-reset busy", 64'(busy), 64'h0);

        // Swept configuration: 64-bit data, register 0 is ordinary storage
        $display("[TB] swept configuration");
        sw_wr_en   = 1'b1;
        sw_wr_addr = 4'd0;
        sw_wr_data = 64'h1234_5678_9ABC_DEF0;
        sw_rd_en   = 3'b001;
        sw_rd_addr = 12'h000;
        @(posedge clk);
        @(negedge clk);
        checkOutput("sweep bypass r0", sw_rd_data[63:0], 64'h1234_5678_9ABC_DEF0);
        sw_wr_en  = 1'b0;
        sw_rd_en  = 3'b111;
        sw_rsv_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("sweep r0 port %0d", k), sw_rd_data[k*64 +: 64],
                        64'h1234_5678_9ABC_DEF0);
        end
        checkOutput("sweep rd_valid", 64'(sw_rd_valid), 64'h7);
        checkOutput("sweep rd_busy", 64'(sw_rd_busy), 64'h7);
        checkOutput("sweep busy", 64'(sw_busy), 64'h0001);
        sw_rd_en  = 3'b000;
        sw_rsv_en = 1'b0;

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
